// File: rtl/axi_async_ch_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_async_ch_rx_if                                                         |
// | Async token-ring lane bus: shared slot array and tokens plus local stream. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface axi_async_ch_rx_if #(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_WIDTH = 8
);
    localparam int c_fill_w = $clog2(BUFFER_WIDTH) + 1;

    logic [BUFFER_WIDTH-1:0]            async_writetoken;
    logic [BUFFER_WIDTH*DATA_WIDTH-1:0] async_data;
    logic [BUFFER_WIDTH-1:0]            async_readpointer;
    logic [DATA_WIDTH-1:0]              data;
    logic                               valid;
    logic                               ready;
    logic [c_fill_w-1:0]                fill;
    logic                               overflow;

    // master = sender plus downstream consumer; slave = the receive lane
    modport master (
        output async_writetoken, async_data, ready,
        input  async_readpointer, data, valid, fill, overflow
    );

    modport slave (
        input  async_writetoken, async_data, ready,
        output async_readpointer, data, valid, fill, overflow
    );
endinterface
`default_nettype wire

// File: rtl/axi_async_ch_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_async_ch_rx                                                            |
// | Receive end of an async token-ring AXI channel lane: syncs the write token,|
// | drains slots into a registered valid/ready stream, returns a Johnson ptr.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module axi_async_ch_rx #(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_WIDTH = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    axi_async_ch_rx_if.slave bus
);
    localparam int c_cnt_w  = $clog2(BUFFER_WIDTH) + 1;
    localparam int c_two_bw = 2 * BUFFER_WIDTH;

    logic [BUFFER_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [BUFFER_WIDTH-1:0] r_rd_ptr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_overflow;

    logic [BUFFER_WIDTH-1:0] w_wr_sync;
    logic [c_cnt_w-1:0]      w_wr_cnt;
    logic [c_cnt_w-1:0]      w_rd_cnt;
    logic [c_cnt_w-1:0]      w_fill;
    logic [c_cnt_w-1:0]      w_slot;
    logic [DATA_WIDTH-1:0]   w_slot_data;
    logic                    w_empty;
    logic                    w_load;

    function automatic logic [c_cnt_w-1:0] johnson_count(input logic [BUFFER_WIDTH-1:0] tok);
        int ones;
        ones = 0;
        for (int i = 0; i < BUFFER_WIDTH; i++) begin
            ones += int'(tok[i]);
        end
        // msb set: second half of the cycle, BW + number of zeros
        if (tok[BUFFER_WIDTH-1]) begin
            return c_cnt_w'(c_two_bw - ones);
        end
        return c_cnt_w'(ones);
    endfunction

    assign w_wr_sync = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_wr_cnt = johnson_count(w_wr_sync);
        w_rd_cnt = johnson_count(r_rd_ptr);
        // modulo 2*BW difference; the add wraps harmlessly in c_cnt_w bits
        if (w_wr_cnt >= w_rd_cnt) begin
            w_fill = w_wr_cnt - w_rd_cnt;
        end else begin
            w_fill = w_wr_cnt + c_cnt_w'(c_two_bw) - w_rd_cnt;
        end
        if (w_rd_cnt >= c_cnt_w'(BUFFER_WIDTH)) begin
            w_slot = w_rd_cnt - c_cnt_w'(BUFFER_WIDTH);
        end else begin
            w_slot = w_rd_cnt;
        end
        w_slot_data = bus.async_data[int'(w_slot)*DATA_WIDTH +: DATA_WIDTH];
        w_empty     = (w_fill == '0);
        w_load      = !w_empty && (!r_valid || bus.ready);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= bus.async_writetoken;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr   <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_data   <= w_slot_data;
                r_valid  <= 1'b1;
                r_rd_ptr <= {r_rd_ptr[BUFFER_WIDTH-2:0], ~r_rd_ptr[BUFFER_WIDTH-1]};
            end else if (r_valid && bus.ready) begin
                r_valid <= 1'b0;
            end
            if (w_fill > c_cnt_w'(BUFFER_WIDTH)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.async_readpointer = r_rd_ptr;
    assign bus.data              = r_data;
    assign bus.valid             = r_valid;
    assign bus.fill              = w_fill;
    assign bus.overflow          = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_axi_async_ch_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_async_ch_rx                                                         |
// | Self-checking bench: vector table, directed corners, random vs model.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_axi_async_ch_rx;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_async_ch_rx_if #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW)) bus ();

    axi_async_ch_rx #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW), .SYNC_STAGES(SS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [DW-1:0] slots [BW];
    always_comb begin
        bus.async_data = '0;
        for (int k = 0; k < BW; k++) begin
            bus.async_data[k*DW +: DW] = slots[k];
        end
    end

    int nchk = 0;
    int nerr = 0;
    int wcnt = 0;

    typedef struct {
        bit          adv;
        logic [63:0] d;
        bit          rdy;
        bit          e_valid;
        logic [63:0] e_data;
        int          e_fill;
        int          e_loads;
    } vec_t;

    // Johnson code for a step count, from the shape of the sequence
    function automatic logic [BW-1:0] jenc(input int c);
        logic [BW-1:0] t;
        int m;
        m = c % (2 * BW);
        for (int i = 0; i < BW; i++) begin
            t[i] = (m < BW) ? (i < m) : (i >= m - BW);
        end
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] d);
        slots[wcnt % BW] = d;
        wcnt++;
        bus.async_writetoken = jenc(wcnt);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        wcnt = 0;
        bus.async_writetoken = '0;
        bus.ready = 1'b0;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 64'(bus.valid), 64'd0);
        chk({tag, "_data"}, bus.data, 64'd0);
        chk({tag, "_rdptr"}, 64'(bus.async_readpointer), 64'd0);
        chk({tag, "_fill"}, 64'(bus.fill), 64'd0);
        chk({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
    endtask

    vec_t          tbl [8];
    logic [DW-1:0] bd  [9];
    logic [DW-1:0] ent [$];
    int            hist [$];

    initial begin
        int m_loads, m_fill, vis;
        bit m_valid, r;
        logic [DW-1:0] d;

        tbl[0] = '{1'b1, 64'hA5,  1'b0, 1'b0, 64'h0,   0, 0};
        tbl[1] = '{1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   0, 0};
        tbl[2] = '{1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   1, 0};
        tbl[3] = '{1'b1, 64'h1B2, 1'b0, 1'b1, 64'hA5,  0, 1};
        tbl[4] = '{1'b0, 64'h0,   1'b0, 1'b1, 64'hA5,  0, 1};
        tbl[5] = '{1'b0, 64'h0,   1'b1, 1'b1, 64'hA5,  1, 1};
        tbl[6] = '{1'b0, 64'h0,   1'b1, 1'b1, 64'h1B2, 0, 2};
        tbl[7] = '{1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   0, 2};

        for (int k = 0; k < BW; k++) slots[k] = '0;
        do_reset(2);

        // reset then idle
        chk_reset_state("reset");
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("idle_valid", 64'(bus.valid), 64'd0);
            chk("idle_fill", 64'(bus.fill), 64'd0);
            chk("idle_rdptr", 64'(bus.async_readpointer), 64'd0);
            chk("idle_ovf", 64'(bus.overflow), 64'd0);
        end

        // single write latency, hold under backpressure, no-bubble reload
        for (int i = 0; i < 8; i++) begin
            chk("tbl_valid", 64'(bus.valid), 64'(tbl[i].e_valid));
            chk("tbl_fill", 64'(bus.fill), 64'(tbl[i].e_fill));
            chk("tbl_rdptr", 64'(bus.async_readpointer), 64'(jenc(tbl[i].e_loads)));
            chk("tbl_ovf", 64'(bus.overflow), 64'd0);
            if (tbl[i].e_valid) chk("tbl_data", bus.data, tbl[i].e_data);
            if (tbl[i].adv) push(tbl[i].d);
            bus.ready = tbl[i].rdy;
            cyc();
        end

        // full buffer (fill == BW) with output register occupied, then drain
        do_reset(2);
        for (int i = 0; i < 9; i++) begin
            bd[i] = {$urandom, $urandom};
            push(bd[i]);
            cyc();
        end
        cyc();
        cyc();
        chk("burst_fill", 64'(bus.fill), 64'd8);
        chk("burst_valid", 64'(bus.valid), 64'd1);
        chk("burst_data0", bus.data, bd[0]);
        chk("burst_ovf", 64'(bus.overflow), 64'd0);
        chk("burst_rdptr", 64'(bus.async_readpointer), 64'(jenc(1)));
        bus.ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            cyc();
            chk("drain_valid", 64'(bus.valid), 64'd1);
            chk("drain_data", bus.data, bd[i]);
        end
        cyc();
        chk("drain_end_valid", 64'(bus.valid), 64'd0);
        chk("drain_end_rdptr", 64'(bus.async_readpointer), 64'(jenc(9)));
        chk("drain_end_fill", 64'(bus.fill), 64'd0);

        // overflow: sender runs one step past a full buffer
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            push({$urandom, $urandom});
            cyc();
        end
        chk("ovf_at_full", 64'(bus.overflow), 64'd0);
        cyc();
        cyc();
        chk("ovf_fill", 64'(bus.fill), 64'd9);
        chk("ovf_set", 64'(bus.overflow), 64'd1);
        repeat (5) cyc();
        chk("ovf_sticky", 64'(bus.overflow), 64'd1);
        do_reset(1);
        chk_reset_state("ovf_rst");

        // random traffic against a count-level model
        m_loads = 0;
        m_valid = 1'b0;
        hist.push_back(0);
        hist.push_back(0);
        for (int t = 0; t < 400; t++) begin
            vis = hist[hist.size()-2];
            m_fill = vis - m_loads;
            chk("rand_valid", 64'(bus.valid), 64'(m_valid));
            chk("rand_rdptr", 64'(bus.async_readpointer), 64'(jenc(m_loads)));
            chk("rand_fill", 64'(bus.fill), 64'(m_fill));
            chk("rand_ovf", 64'(bus.overflow), 64'd0);
            if (m_valid) chk("rand_data", bus.data, ent[m_loads-1]);
            r = (t < 150) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.ready = r;
            if ($urandom_range(0, 99) < 70 && (wcnt - m_loads) < BW) begin
                d = {$urandom, $urandom};
                ent.push_back(d);
                push(d);
            end
            hist.push_back(wcnt);
            if (m_fill > 0 && (!m_valid || r)) begin
                m_loads++;
                m_valid = 1'b1;
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
            cyc();
        end
        chk("rand_enough_writes", 64'(wcnt > 2 * BW + 4), 64'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
`default_nettype wire
